// File: rtl/top3_reporter.sv
// top3_reporter
//   Captures a snapshot of the three largest values reported by an upstream
//   top-3 finder and streams them out as a short report over a
//   valid/ready handshake, largest first.
//
//   Optional feature: define TOP3_REPORTER_SUM_EN to append a fourth word
//   holding the modulo-2^WIDTH sum of the three snapshot values. Unfilled
//   slots (EMPTY_VAL) count as 0 in that sum. With the macro undefined the
//   report is exactly three words and no adder is built.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   snap       single-cycle request to capture res_2/res_1/res_0
//   res_2      largest upstream value
//   res_1      second-largest upstream value
//   res_0      third-largest upstream value
//   out_data   streamed word (0 when out_valid is low)
//   out_valid  out_data holds a word of the report
//   out_ready  consumer accepts out_data
//   out_last   current word is the final word of the report
//   out_empty  current word is an unfilled slot (EMPTY_VAL)
//   busy       a report is in progress
//   drop_cnt   saturating count of snap requests rejected while busy
module top3_reporter #(
  parameter int              WIDTH     = 32,
  parameter logic [WIDTH-1:0] EMPTY_VAL = 32'h80000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             snap,
  input  logic [WIDTH-1:0] res_2,
  input  logic [WIDTH-1:0] res_1,
  input  logic [WIDTH-1:0] res_0,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             out_empty,
  output logic             busy,
  output logic [7:0]       drop_cnt
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  // Index of the final word: the sum word when enabled, otherwise res_0.
`ifdef TOP3_REPORTER_SUM_EN
  localparam logic [1:0] LAST_IDX = 2'd3;
`else
  localparam logic [1:0] LAST_IDX = 2'd2;
`endif

  state_t           state, state_next;
  logic [1:0]       idx, idx_next;
  logic [WIDTH-1:0] cap_2, cap_1, cap_0;
  logic             load;
  logic             drop;

`ifdef TOP3_REPORTER_SUM_EN
  // Unfilled slots contribute nothing to the sum.
  logic [WIDTH-1:0] sum_word;
  assign sum_word = ((cap_2 == EMPTY_VAL) ? '0 : cap_2) +
                    ((cap_1 == EMPTY_VAL) ? '0 : cap_1) +
                    ((cap_0 == EMPTY_VAL) ? '0 : cap_0);
`endif

  // State, word index, snapshot and drop counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= 2'd0;
      cap_2    <= '0;
      cap_1    <= '0;
      cap_0    <= '0;
      drop_cnt <= 8'd0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (load) begin
        cap_2 <= res_2;
        cap_1 <= res_1;
        cap_0 <= res_0;
      end
      if (drop && (drop_cnt != 8'd255)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // Next-state logic. Any snap seen in SEND is rejected, including the
  // cycle of the final handshake, because the state is still SEND then.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    load       = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (snap) begin
          load       = 1'b1;
          idx_next   = 2'd0;
          state_next = SEND;
        end
      end
      SEND: begin
        drop = snap;
        if (out_ready) begin
          if (idx == LAST_IDX) begin
            state_next = IDLE;
            idx_next   = 2'd0;
          end else begin
            idx_next = idx + 2'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = 2'd0;
      end
    endcase
  end

  // Output decode. Words come straight from the held snapshot and index,
  // so they stay stable under backpressure and read as 0 when idle.
  always_comb begin
    out_valid = (state == SEND);
    busy      = (state == SEND);
    out_data  = '0;
    out_last  = 1'b0;
    out_empty = 1'b0;
    if (state == SEND) begin
      out_last = (idx == LAST_IDX);
      case (idx)
        2'd0: begin
          out_data  = cap_2;
          out_empty = (cap_2 == EMPTY_VAL);
        end
        2'd1: begin
          out_data  = cap_1;
          out_empty = (cap_1 == EMPTY_VAL);
        end
        2'd2: begin
          out_data  = cap_0;
          out_empty = (cap_0 == EMPTY_VAL);
        end
        default: begin
`ifdef TOP3_REPORTER_SUM_EN
          out_data = sum_word;
`else
          out_data = '0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_top3_reporter.sv
// tb_top3_reporter
//   Drives top3_reporter with directed scenarios followed by randomized
//   traffic, and compares every output each cycle against a reference
//   model that holds the pending report as a queue of expected words.
//   Honours TOP3_REPORTER_SUM_EN the same way the design does.
module tb_top3_reporter;

  localparam logic [31:0] EMPTY = 32'h80000000;

  typedef struct {
    logic [31:0] data;
    logic        empty;
  } word_t;

  logic        clk;
  logic        reset;
  logic        snap;
  logic [31:0] res_2, res_1, res_0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        out_empty;
  logic        busy;
  logic [7:0]  drop_cnt;

  word_t       m_q[$];
  int          m_drop;
  int          check_count;
  int          fail_count;

  top3_reporter dut (
    .clk       (clk),
    .reset     (reset),
    .snap      (snap),
    .res_2     (res_2),
    .res_1     (res_1),
    .res_0     (res_0),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_empty (out_empty),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Report contents as defined by the snapshot: largest first, then the
  // optional sum word with empty slots counted as zero.
  task automatic buildReport(input logic [31:0] r2, input logic [31:0] r1,
                             input logic [31:0] r0);
    logic [31:0] vals[3];
    logic [31:0] total;
    vals[0] = r2;
    vals[1] = r1;
    vals[2] = r0;
    total   = 32'd0;
    for (int i = 0; i < 3; i++) begin
      m_q.push_back('{data: vals[i], empty: (vals[i] == EMPTY)});
      if (vals[i] != EMPTY) total = total + vals[i];
    end
`ifdef TOP3_REPORTER_SUM_EN
    m_q.push_back('{data: total, empty: 1'b0});
`endif
  endtask

  // Called at a falling edge: compare DUT against the model, drive the
  // next inputs, advance the model over the coming rising edge, and wait
  // for the next falling edge.
  task automatic applyStimulus(input logic rst_n, input logic snp, input logic rdy,
                               input logic [31:0] r2, input logic [31:0] r1,
                               input logic [31:0] r0);
    logic exp_valid;
    exp_valid = (m_q.size() != 0);
    checkOutput("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    checkOutput("busy", {31'd0, busy}, {31'd0, exp_valid});
    checkOutput("drop_cnt", {24'd0, drop_cnt}, m_drop[31:0]);
    if (exp_valid) begin
      checkOutput("out_data", out_data, m_q[0].data);
      checkOutput("out_last", {31'd0, out_last}, {31'd0, (m_q.size() == 1)});
      checkOutput("out_empty", {31'd0, out_empty}, {31'd0, m_q[0].empty});
    end else begin
      checkOutput("idle_data", out_data, 32'd0);
      checkOutput("idle_last", {31'd0, out_last}, 32'd0);
      checkOutput("idle_empty", {31'd0, out_empty}, 32'd0);
    end

    reset     = rst_n;
    snap      = snp;
    out_ready = rdy;
    res_2     = r2;
    res_1     = r1;
    res_0     = r0;

    if (!rst_n) begin
      m_q.delete();
      m_drop = 0;
    end else if (m_q.size() != 0) begin
      if (snp && m_drop < 255) m_drop++;
      if (rdy) void'(m_q.pop_front());
    end else if (snp) begin
      buildReport(r2, r1, r0);
    end

    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 1, 32'd0, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] randVal();
    case ($urandom_range(0, 3))
      0:       randVal = EMPTY;
      1:       randVal = 32'($urandom_range(0, 50));
      default: randVal = $urandom;
    endcase
  endfunction

  initial begin
    check_count = 0;
    fail_count  = 0;
    m_drop      = 0;
    reset       = 1'b0;
    snap        = 1'b0;
    out_ready   = 1'b0;
    res_2       = 32'd0;
    res_1       = 32'd0;
    res_0       = 32'd0;
    @(negedge clk);
    @(negedge clk);

    // Reset state, and a snap coinciding with reset is ignored.
    applyStimulus(0, 1, 1, 32'd1, 32'd2, 32'd3);
    idleCycles(2);

    // Basic report.
    applyStimulus(1, 1, 1, 32'd30, 32'd20, 32'd10);
    idleCycles(6);

    // Backpressure while the upstream values change.
    applyStimulus(1, 1, 0, 32'd30, 32'd20, 32'd10);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 32'd99, 32'd99, 32'd99);
    checkOutput("bp_hold", out_data, 32'd30);
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 1, 32'd99, 32'd99, 32'd99);

    // Empty slots.
    applyStimulus(1, 1, 1, 32'd5, EMPTY, EMPTY);
    idleCycles(6);

    // Drops during SEND and in the final handshake cycle.
    applyStimulus(0, 0, 1, 32'd0, 32'd0, 32'd0);
    applyStimulus(1, 1, 1, 32'd30, 32'd20, 32'd10);
    applyStimulus(1, 1, 1, 32'd30, 32'd20, 32'd10);
    applyStimulus(1, 0, 1, 32'd30, 32'd20, 32'd10);
`ifdef TOP3_REPORTER_SUM_EN
    applyStimulus(1, 0, 1, 32'd30, 32'd20, 32'd10);
`endif
    applyStimulus(1, 1, 1, 32'd30, 32'd20, 32'd10);
    checkOutput("drops_two", {24'd0, drop_cnt}, 32'd2);
    idleCycles(3);

    // Saturation of the drop counter.
    applyStimulus(1, 1, 0, 32'd7, 32'd8, 32'd9);
    for (int i = 0; i < 300; i++) applyStimulus(1, 1, 0, 32'd7, 32'd8, 32'd9);
    checkOutput("drop_sat", {24'd0, drop_cnt}, 32'd255);
    idleCycles(6);

    // Reset mid-report, then a fresh full report.
    applyStimulus(1, 1, 1, 32'd30, 32'd20, 32'd10);
    applyStimulus(1, 0, 1, 32'd0, 32'd0, 32'd0);
    applyStimulus(0, 0, 1, 32'd0, 32'd0, 32'd0);
    checkOutput("abort_valid", {31'd0, out_valid}, 32'd0);
    applyStimulus(1, 0, 1, 32'd0, 32'd0, 32'd0);
    applyStimulus(1, 1, 1, 32'd40, 32'd41, 32'd42);
    idleCycles(6);

    // Sum wrap-around values.
    applyStimulus(1, 1, 1, 32'hFFFFFFFF, 32'd1, 32'd1);
    idleCycles(6);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 2) != 0), randVal(), randVal(), randVal());
    end
    idleCycles(6);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule

// File: doc/top3_reporter.md
TOP3_REPORTER -- requirements
Module: top3_reporter

Interface
REQ-001 Parameter WIDTH, default 32, data word width.
REQ-002 Parameter EMPTY_VAL, default 32'h80000000, sentinel value marking an unfilled top-3 slot.
REQ-003 clk  input  1  rising-edge clock, the only clock.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on clk.
REQ-005 snap  input  1  single-cycle request to capture the current top-3 values.
REQ-006 res_2  input  WIDTH  largest value from the upstream top-3 finder.
REQ-007 res_1  input  WIDTH  second-largest value.
REQ-008 res_0  input  WIDTH  third-largest value.
REQ-009 out_data  output  WIDTH  streamed word.
REQ-010 out_valid  output  1  out_data is valid.
REQ-011 out_ready  input  1  consumer accepts out_data.
REQ-012 out_last  output  1  current word is the final word of the report.
REQ-013 out_empty  output  1  current word is an unfilled slot.
REQ-014 busy  output  1  a report is in progress.
REQ-015 drop_cnt  output  8  saturating count of rejected snap requests.

Function
REQ-016 The block SHALL have two states: IDLE and SEND.
REQ-017 In IDLE with snap=1, the block SHALL capture res_2, res_1 and res_0 into internal registers and enter SEND on the next edge.
REQ-018 out_valid and busy SHALL assert in the cycle after the accepting snap; the latency is 1 cycle.
REQ-019 A word SHALL transfer on any edge where out_valid=1 and out_ready=1.
REQ-020 Word order SHALL be: snapshot res_2, then res_1, then res_0.
REQ-021 out_data, out_last and out_empty SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 out_last SHALL be 1 only on the final word of the report.
REQ-023 out_empty SHALL be 1 when a data word equals EMPTY_VAL, and 0 otherwise.
REQ-024 After the final word transfers, the block SHALL return to IDLE, and out_valid and busy SHALL be 0 in the following cycle.
REQ-025 The upstream inputs SHALL be ignored after capture; changes to them during SEND SHALL NOT affect the report.
REQ-026 A snap=1 in SEND, including the cycle of the final handshake, SHALL be rejected and SHALL increment drop_cnt.
REQ-027 drop_cnt SHALL saturate at 255.
REQ-028 A snap=1 in IDLE SHALL never increment drop_cnt.
REQ-029 When out_valid=0, out_data, out_last and out_empty SHALL be 0.
REQ-030 out_ready=1 while out_valid=0 SHALL have no effect.

Reset
REQ-031 When reset=0 at a clk edge, the block SHALL enter IDLE with out_valid=0, out_data=0, out_last=0, out_empty=0, busy=0, drop_cnt=0, and all snapshot registers cleared to 0.
REQ-032 A reset during SEND SHALL abort the report: out_valid=0 from the next cycle, with no resumption and no partial replay.
REQ-033 A snap coinciding with reset=0 SHALL be ignored.

Configuration
REQ-034 When the macro TOP3_REPORTER_SUM_EN is defined, the block SHALL append a fourth word after res_0.
REQ-035 This fourth word SHALL be the sum of the three snapshot values modulo 2^WIDTH, with each EMPTY_VAL slot counted as 0.
REQ-036 When TOP3_REPORTER_SUM_EN is defined, out_last SHALL move to the sum word, and out_empty SHALL be 0 on the sum word.
REQ-037 When TOP3_REPORTER_SUM_EN is undefined, the report SHALL be exactly three words, with no sum logic present.

Verification
REQ-038 Basic report: res_2/1/0=30/20/10, snap pulse, out_ready=1 -> words 30, 20, 10 on consecutive cycles starting 1 cycle after snap; out_last on 10 (SUM_EN: a fourth word 60 with out_last); busy then drops.
REQ-039 Backpressure: out_ready held 0 for 5 cycles after out_valid rises, while the res inputs change to 99 -> out_data holds 30 throughout; the report is still 30, 20, 10.
REQ-040 Empty slots: res_2=5, res_1=res_0=32'h80000000 -> out_empty=0,1,1 (SUM_EN: sum word 5, out_empty=0).
REQ-041 Drops: snap during SEND, then snap in the final-handshake cycle -> drop_cnt=2, no second report; 300 rejected snaps -> drop_cnt=255.
REQ-042 Reset mid-report: reset=0 after the first word transfers -> out_valid=0 the next cycle, all outputs 0; a new snap then yields a full fresh report.
REQ-043 Wrap-around (SUM_EN): res values 32'hFFFFFFFF, 1, 1 -> sum word 32'h00000001.
